// File: rtl/vga_multibuf_frame_if.sv
// CPU write bus into the VGA multi-buffer frame store.
// The master drives byte-addressed 32-bit writes; the frame store only listens.
interface vga_multibuf_frame_if;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/vga_multibuf_frame.sv
// N-way VGA frame-buffer store: CPU fills the back buffer, scan reads the front buffer,
// swaps are deferred to frame end. Define VGA_FB_CLEAR_EN to zero each released buffer in hardware.
module vga_multibuf_frame #(
    parameter int          NUM_BUFS  = 2,
    parameter int          H_PIX     = 160,
    parameter int          V_PIX     = 120,
    parameter int          COLOR_W   = 12,
    parameter logic [31:0] BASE_ADDR = 32'h1002_0000,
    parameter logic [31:0] SWAP_ADDR = 32'h1003_0000
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    vga_multibuf_frame_if.slave           cpu,
    input  logic [$clog2(H_PIX)-1:0]      i_rd_x,
    input  logic [$clog2(V_PIX)-1:0]      i_rd_y,
    input  logic                          i_frame_end,
    output logic [COLOR_W-1:0]            o_color,
    output logic [$clog2(NUM_BUFS)-1:0]   o_disp_idx,
    output logic [$clog2(NUM_BUFS)-1:0]   o_wr_idx,
    output logic                          o_swap_pending,
    output logic                          o_swap_ovf,
    output logic                          o_wr_drop,
    output logic                          o_clear_busy
);

    localparam int PIX   = H_PIX * V_PIX;
    localparam int PIX_W = $clog2(PIX);
    localparam int XW    = $clog2(H_PIX);
    localparam int YW    = $clog2(V_PIX);
    localparam int IDX_W = $clog2(NUM_BUFS);

    localparam logic [31:0]      WIN_BYTES = 32'(4 * PIX);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BUFS - 1);

    typedef enum logic {S_IDLE, S_PENDING} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   disp_idx, disp_nxt;
    logic [IDX_W-1:0]   wr_idx, wr_nxt;
    logic [IDX_W-1:0]   ready_idx, ready_nxt;
    logic [IDX_W-1:0]   wr_step;

    logic [31:0]        wr_off;
    logic [PIX_W-1:0]   pix_idx;
    logic               pix_hit, swap_req;
    logic               pix_block, pix_we_c, wr_drop_c, swap_ovf_c, swap_done;

    logic               clr_busy;
    logic [IDX_W-1:0]   clr_idx;
    logic [PIX_W-1:0]   clr_addr;

    logic [COLOR_W-1:0] mem [NUM_BUFS][PIX];
    logic [NUM_BUFS-1:0] bank_we;
    logic [PIX_W-1:0]   bank_addr [NUM_BUFS];
    logic [COLOR_W-1:0] bank_data [NUM_BUFS];

    logic [PIX_W-1:0]   rd_addr;
    logic               rd_ok;
    logic               unused_wr_data;

    assign unused_wr_data = ^cpu.wr_data[31:COLOR_W];

    // Address decode: the subtraction wraps for addresses below BASE_ADDR, hence the explicit lower bound.
    assign wr_off   = cpu.wr_addr - BASE_ADDR;
    assign pix_hit  = cpu.wr_en && (cpu.wr_addr >= BASE_ADDR) && (wr_off < WIN_BYTES);
    assign pix_idx  = wr_off[PIX_W+1:2];
    assign swap_req = cpu.wr_en && (cpu.wr_addr == SWAP_ADDR);

    function automatic logic [IDX_W-1:0] bump(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        wr_step = bump(wr_idx);
        if (wr_step == disp_idx) wr_step = bump(wr_step);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= S_IDLE;
            disp_idx   <= '0;
            wr_idx     <= IDX_W'(1);
            ready_idx  <= '0;
            o_swap_ovf <= 1'b0;
            o_wr_drop  <= 1'b0;
        end else begin
            state      <= state_nxt;
            disp_idx   <= disp_nxt;
            wr_idx     <= wr_nxt;
            ready_idx  <= ready_nxt;
            o_swap_ovf <= swap_ovf_c;
            o_wr_drop  <= wr_drop_c;
        end
    end

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        disp_nxt  = disp_idx;
        wr_nxt    = wr_idx;
        ready_nxt = ready_idx;
        case (state)
            S_IDLE: begin
                if (swap_req && !clr_busy) begin
                    ready_nxt = wr_idx;
                    state_nxt = S_PENDING;
                    if (NUM_BUFS >= 3) wr_nxt = wr_step;
                end
            end
            S_PENDING: begin
                if (i_frame_end) begin
                    disp_nxt  = ready_idx;
                    state_nxt = S_IDLE;
                    if (NUM_BUFS == 2) wr_nxt = disp_idx;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_swap_pending = (state == S_PENDING);
        swap_done      = (state == S_PENDING) && i_frame_end;
        swap_ovf_c     = swap_req && ((state == S_PENDING) || clr_busy);
        // With two buffers the write buffer is the one queued for display while pending.
        pix_block      = ((NUM_BUFS == 2) && (state == S_PENDING)) ||
                         (clr_busy && (wr_idx == clr_idx));
        pix_we_c       = pix_hit && !pix_block;
        wr_drop_c      = pix_hit && pix_block;
    end

`ifdef VGA_FB_CLEAR_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            clr_busy <= 1'b0;
            clr_idx  <= '0;
            clr_addr <= '0;
        end else if (swap_done) begin
            clr_busy <= 1'b1;
            clr_idx  <= disp_idx;
            clr_addr <= '0;
        end else if (clr_busy) begin
            if (clr_addr == PIX_W'(PIX - 1)) clr_busy <= 1'b0;
            clr_addr <= clr_addr + 1'b1;
        end
    end
`else
    logic unused_swap_done;
    assign unused_swap_done = swap_done;
    assign clr_busy = 1'b0;
    assign clr_idx  = '0;
    assign clr_addr = '0;
`endif

    assign o_clear_busy = clr_busy;
    assign o_disp_idx   = disp_idx;
    assign o_wr_idx     = wr_idx;

    // Clear and CPU never target the same bank in one cycle, so each bank keeps a single write port.
    always_comb begin
        for (int b = 0; b < NUM_BUFS; b++) begin
            bank_we[b]   = 1'b0;
            bank_addr[b] = pix_idx;
            bank_data[b] = cpu.wr_data[COLOR_W-1:0];
            if (clr_busy && (clr_idx == IDX_W'(b))) begin
                bank_we[b]   = 1'b1;
                bank_addr[b] = clr_addr;
                bank_data[b] = '0;
            end else if (pix_we_c && (wr_idx == IDX_W'(b))) begin
                bank_we[b] = 1'b1;
            end
        end
    end

    // NOTE: pixel storage is deliberately left out of reset; it is a RAM, not control state.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < NUM_BUFS; b++) begin
            if (bank_we[b]) mem[b][bank_addr[b]] <= bank_data[b];
        end
    end

    assign rd_addr = PIX_W'(i_rd_y) * PIX_W'(H_PIX) + PIX_W'(i_rd_x);
    assign rd_ok   = ({1'b0, i_rd_x} < (XW+1)'(H_PIX)) && ({1'b0, i_rd_y} < (YW+1)'(V_PIX));

    always_ff @(posedge i_clk) begin
        if (i_reset)    o_color <= '0;
        else if (rd_ok) o_color <= mem[disp_idx][rd_addr];
        else            o_color <= '0;
    end

endmodule

// File: tb/tb_vga_multibuf_frame.sv
// Directed bench for vga_multibuf_frame: a two-buffer and a three-buffer instance side by side.
// With VGA_FB_CLEAR_EN defined the two-buffer instance runs the hardware-clear sequence instead.
module tb_vga_multibuf_frame;

    localparam logic [31:0] BASE = 32'h1002_0000;
    localparam logic [31:0] SWAP = 32'h1003_0000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rd_x = '0;
    logic [6:0] rd_y = '0;
    logic       fe2 = 1'b0, fe3 = 1'b0;

    logic [11:0] color2, color3;
    logic        disp2, wr2;
    logic [1:0]  disp3, wr3;
    logic        pend2, ovf2, drop2, busy2;
    logic        pend3, ovf3, drop3, busy3;

    int n_vec = 0;
    int n_err = 0;

    vga_multibuf_frame_if bus2 ();
    vga_multibuf_frame_if bus3 ();

    vga_multibuf_frame #(.NUM_BUFS(2)) dut2 (
        .i_clk(clk), .i_reset(rst), .cpu(bus2.slave),
        .i_rd_x(rd_x), .i_rd_y(rd_y), .i_frame_end(fe2),
        .o_color(color2), .o_disp_idx(disp2), .o_wr_idx(wr2),
        .o_swap_pending(pend2), .o_swap_ovf(ovf2), .o_wr_drop(drop2), .o_clear_busy(busy2)
    );

    vga_multibuf_frame #(.NUM_BUFS(3)) dut3 (
        .i_clk(clk), .i_reset(rst), .cpu(bus3.slave),
        .i_rd_x(rd_x), .i_rd_y(rd_y), .i_frame_end(fe3),
        .o_color(color3), .o_disp_idx(disp3), .o_wr_idx(wr3),
        .o_swap_pending(pend3), .o_swap_ovf(ovf3), .o_wr_drop(drop3), .o_clear_busy(busy3)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic [31:0] a, input logic [31:0] d);
        if (sel == 2) begin
            bus2.wr_en = 1'b1; bus2.wr_addr = a; bus2.wr_data = d;
        end else begin
            bus3.wr_en = 1'b1; bus3.wr_addr = a; bus3.wr_data = d;
        end
    endtask

    task automatic release_bus();
        bus2.wr_en = 1'b0;
        bus3.wr_en = 1'b0;
    endtask

    task automatic cpu_wr(input int sel, input logic [31:0] a, input logic [31:0] d);
        drive(sel, a, d);
        tick();
        release_bus();
    endtask

    function automatic logic [31:0] pix_addr(input int x, input int y);
        return BASE + 32'(4 * (y * 160 + x));
    endfunction

    task automatic frame_end(input int sel);
        if (sel == 2) fe2 = 1'b1; else fe3 = 1'b1;
        tick();
        fe2 = 1'b0;
        fe3 = 1'b0;
    endtask

    task automatic rd(input int x, input int y);
        rd_x = 8'(x);
        rd_y = 7'(y);
        tick();
    endtask

    initial begin
        bus2.wr_en = 1'b0; bus2.wr_addr = '0; bus2.wr_data = '0;
        bus3.wr_en = 1'b0; bus3.wr_addr = '0; bus3.wr_data = '0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_disp2", 32'(disp2), 0);
        check("rst_wr2", 32'(wr2), 1);
        check("rst_pend2", 32'(pend2), 0);
        check("rst_ovf2", 32'(ovf2), 0);
        check("rst_drop2", 32'(drop2), 0);
        check("rst_busy2", 32'(busy2), 0);
        check("rst_color2", 32'(color2), 0);
        check("rst_disp3", 32'(disp3), 0);
        check("rst_wr3", 32'(wr3), 1);

`ifdef VGA_FB_CLEAR_EN
        begin
            int n;
            cpu_wr(2, pix_addr(3, 5), 32'h123);
            cpu_wr(2, pix_addr(159, 119), 32'h999);
            cpu_wr(2, SWAP, 0);
            frame_end(2);
            check("clr_disp_after_swap", 32'(disp2), 1);
            check("clr_busy_start", 32'(busy2), 1);
            cpu_wr(2, SWAP, 0);
            check("clr_swap_rejected", 32'(ovf2), 1);
            check("clr_no_pending", 32'(pend2), 0);
            cpu_wr(2, pix_addr(0, 0), 32'h5A5);
            check("clr_wr_dropped", 32'(drop2), 1);
            n = 2;
            while (busy2 && n < 30000) begin
                n++;
                tick();
            end
            check("clr_busy_cycles", 32'(n), 19200);
            // Second swap releases buffer 1; a third makes it visible again.
            cpu_wr(2, SWAP, 0);
            frame_end(2);
            n = 0;
            while (busy2 && n < 30000) begin
                n++;
                tick();
            end
            check("clr2_busy_cycles", 32'(n), 19200);
            cpu_wr(2, SWAP, 0);
            frame_end(2);
            check("clr_disp_back", 32'(disp2), 1);
            rd(3, 5);
            check("clr_pix_3_5", 32'(color2), 0);
            rd(159, 119);
            check("clr_pix_last", 32'(color2), 0);
        end
`else
        // Two buffers: fill back buffer, swap, read it on the front.
        cpu_wr(2, pix_addr(3, 5), 32'h123);
        check("wr_no_drop", 32'(drop2), 0);
        cpu_wr(2, SWAP, 32'hDEAD_BEEF);
        check("swap_pending", 32'(pend2), 1);
        check("swap_wr_idx_held", 32'(wr2), 1);
        check("swap_no_ovf", 32'(ovf2), 0);
        frame_end(2);
        check("swap_disp", 32'(disp2), 1);
        check("swap_wr", 32'(wr2), 0);
        check("swap_pend_clr", 32'(pend2), 0);
        rd(3, 5);
        check("read_swapped", 32'(color2), 32'h123);

        cpu_wr(2, pix_addr(3, 5), 32'hABC);
        check("read_front_kept", 32'(color2), 32'h123);
        cpu_wr(2, SWAP, 0);
        cpu_wr(2, pix_addr(3, 5), 32'h555);
        check("pend_wr_drop", 32'(drop2), 1);
        tick();
        check("drop_is_pulse", 32'(drop2), 0);
        cpu_wr(2, SWAP, 0);
        check("pend_swap_ovf", 32'(ovf2), 1);
        check("ovf_pend_kept", 32'(pend2), 1);
        check("ovf_disp_kept", 32'(disp2), 1);
        check("ovf_wr_kept", 32'(wr2), 0);
        tick();
        check("ovf_is_pulse", 32'(ovf2), 0);

        // Pixel write on the frame-end cycle is still dropped.
        drive(2, pix_addr(3, 5), 32'h666);
        frame_end(2);
        release_bus();
        check("fe_cycle_drop", 32'(drop2), 1);
        check("fe_disp", 32'(disp2), 0);
        check("fe_wr", 32'(wr2), 1);
        tick();
        check("read_buf0", 32'(color2), 32'hABC);

        // Swap request coincident with frame end from IDLE waits a full frame.
        drive(2, SWAP, 0);
        frame_end(2);
        release_bus();
        check("coinc_pending", 32'(pend2), 1);
        check("coinc_disp_held", 32'(disp2), 0);
        tick();
        check("coinc_disp_still", 32'(disp2), 0);
        frame_end(2);
        check("coinc_disp_next", 32'(disp2), 1);
        check("coinc_wr_next", 32'(wr2), 0);
        tick();
        check("coinc_read", 32'(color2), 32'h123);
        rd(200, 5);
        check("read_x_oob", 32'(color2), 0);
        rd(3, 120);
        check("read_y_oob", 32'(color2), 0);

        // Byte offset ignored, upper data bits ignored, out-of-window write ignored.
        cpu_wr(2, pix_addr(3, 5) + 32'd2, 32'hFFFF_F7EF);
        cpu_wr(2, BASE + 32'd76800, 32'h111);
        check("oow_no_drop", 32'(drop2), 0);
        check("oow_no_pend", 32'(pend2), 0);
        cpu_wr(2, BASE - 32'd4, 32'h222);
        check("below_no_drop", 32'(drop2), 0);
        cpu_wr(2, SWAP, 0);
        frame_end(2);
        rd(3, 5);
        check("read_byteoff", 32'(color2), 32'h7EF);

        // Three buffers: write index advances at request, writes continue while pending.
        cpu_wr(3, pix_addr(0, 0), 32'h321);
        cpu_wr(3, SWAP, 0);
        check("tri_wr_adv", 32'(wr3), 2);
        check("tri_pending", 32'(pend3), 1);
        cpu_wr(3, pix_addr(0, 0), 32'h456);
        check("tri_no_drop", 32'(drop3), 0);
        frame_end(3);
        check("tri_disp", 32'(disp3), 1);
        check("tri_wr", 32'(wr3), 2);
        rd(0, 0);
        check("tri_read_b1", 32'(color3), 32'h321);
        cpu_wr(3, SWAP, 0);
        check("tri_wr_adv2", 32'(wr3), 0);
        frame_end(3);
        check("tri_disp2", 32'(disp3), 2);
        tick();
        check("tri_read_b2", 32'(color3), 32'h456);

        // Reset while pending cancels the swap.
        cpu_wr(2, SWAP, 0);
        check("pre_rst_pending", 32'(pend2), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_pend", 32'(pend2), 0);
        check("midrst_disp", 32'(disp2), 0);
        check("midrst_wr", 32'(wr2), 1);
        frame_end(2);
        check("midrst_no_swap", 32'(disp2), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
